// File: rtl/ecc_pkg.sv
// Shared GF(2^163) definitions: field degree, reduction polynomial, divider state encoding
// and the halve-modulo-f helper used by the binary divider.
package ecc_pkg;

    localparam int M = 163;
    localparam logic [M:0] F_POLY = {1'b1, 155'd0, 8'hC9};
    localparam int MAX_DIV_STEPS = 2 * M - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ITER = ST_ITER,
        DONE = ST_DONE
    } div_state_t;

    // w / x mod f: add f first when w is odd so the shift drops a zero bit
    function automatic logic [M-1:0] half_x(input logic [M-1:0] w);
        logic [M:0] t;
        t = w[0] ? ({1'b0, w} ^ F_POLY) : {1'b0, w};
        return t[M:1];
    endfunction

endpackage

// File: rtl/gf163_deg_cmp.sv
// Combinational degree comparator: a_gt_b = deg(a) > deg(b), with deg(0) taken as 0.
module gf163_deg_cmp
    import ecc_pkg::*;
(
    input  logic [M:0] a,
    input  logic [M:0] b,
    output logic       a_gt_b
);

    function automatic logic [7:0] deg_of(input logic [M:0] v);
        deg_of = '0;
        for (int i = 0; i <= M; i++) begin
            if (v[i]) deg_of = 8'(i);
        end
    endfunction

    assign a_gt_b = deg_of(a) > deg_of(b);

endmodule

// File: rtl/gf163_divider.sv
// GF(2^163) binary modular divider: x_out = x_in / z_in mod f, one reduction step per clock.
// Optional GF_DIV_WATCHDOG_EN adds a step counter that aborts runaway iterations.
module gf163_divider
    import ecc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] x_in,
    input  logic [M-1:0] z_in,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] x_out,
    output logic         div_zero
);

    div_state_t   state_q, state_d;
    logic [M:0]   a_q, a_d, b_q, b_d;
    logic [M-1:0] u_q, u_d, v_q, v_d;
    logic [M-1:0] x_out_q, x_out_d;
    logic         busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;
    logic         a_gt_b;
    logic [M:0]   ab_x;
    logic [M-1:0] uv_x;
`ifdef GF_DIV_WATCHDOG_EN
    logic [8:0]   step_q, step_d;
`endif

    assign ab_x = a_q ^ b_q;
    assign uv_x = u_q ^ v_q;

    gf163_deg_cmp u_deg_cmp (
        .a      (a_q),
        .b      (b_q),
        .a_gt_b (a_gt_b)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        u_d        = u_q;
        v_d        = v_q;
        x_out_d    = x_out_q;
        div_zero_d = div_zero_q;
`ifdef GF_DIV_WATCHDOG_EN
        step_d     = step_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (z_in == '0) begin
                        div_zero_d = 1'b1;
                        x_out_d    = '0;
                        state_d    = DONE;
                    end else begin
                        a_d        = {1'b0, z_in};
                        b_d        = F_POLY;
                        u_d        = x_in;
                        v_d        = '0;
                        div_zero_d = 1'b0;
`ifdef GF_DIV_WATCHDOG_EN
                        step_d     = '0;
`endif
                        state_d    = ITER;
                    end
                end
            end
            ITER: begin
                if (a_q == b_q) begin
                    x_out_d = u_q;
                    state_d = DONE;
                end
`ifdef GF_DIV_WATCHDOG_EN
                else if (step_q == 9'(MAX_DIV_STEPS + 1)) begin
                    x_out_d    = '0;
                    div_zero_d = 1'b1;
                    state_d    = DONE;
                end
`endif
                else begin
`ifdef GF_DIV_WATCHDOG_EN
                    step_d = step_q + 9'd1;
`endif
                    // Invariants U*z == A*x and V*z == B*x (mod f) hold across every rule
                    if (!a_q[0]) begin
                        a_d = a_q >> 1;
                        u_d = half_x(u_q);
                    end else if (!b_q[0]) begin
                        b_d = b_q >> 1;
                        v_d = half_x(v_q);
                    end else if (a_gt_b) begin
                        a_d = ab_x >> 1;
                        u_d = half_x(uv_x);
                    end else begin
                        b_d = ab_x >> 1;
                        v_d = half_x(uv_x);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ITER);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            u_q        <= '0;
            v_q        <= '0;
            x_out_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef GF_DIV_WATCHDOG_EN
            step_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            u_q        <= u_d;
            v_q        <= v_d;
            x_out_q    <= x_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
`ifdef GF_DIV_WATCHDOG_EN
            step_q     <= step_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign x_out    = x_out_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_gf163_divider.sv
// Scoreboard bench for gf163_divider; expected quotients come from a Fermat-inversion model.
module tb_gf163_divider;
    import ecc_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [M-1:0] x_in = '0;
    logic [M-1:0] z_in = '0;
    logic         busy, done, div_zero;
    logic [M-1:0] x_out;

    typedef struct {
        logic [M-1:0] x;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    gf163_divider dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x_in     (x_in),
        .z_in     (z_in),
        .busy     (busy),
        .done     (done),
        .x_out    (x_out),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [M:0] got, input logic [M:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic         c;
        r = '0;
        for (int i = M - 1; i >= 0; i--) begin
            c = r[M-1];
            r = r << 1;
            if (c) r = r ^ {155'd0, 8'hC9};
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    // z^(2^163-2) = product of z^(2^i) for i = 1..162
    function automatic logic [M-1:0] gf_inv(input logic [M-1:0] z);
        logic [M-1:0] p, r;
        p = z;
        r = {{(M-1){1'b0}}, 1'b1};
        for (int i = 1; i < M; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [M-1:0] rand163();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        if (t[M-1:0] == '0) t[0] = 1'b1;
        return t[M-1:0];
    endfunction

    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("x_out", x_out, mon_e.x);
                checkOutput("div_zero", div_zero, mon_e.dz);
                checkOutput("busy_at_done", busy, 0);
            end
        end
    end

    task automatic waitDone(input bit zero_div, input bit inject);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= MAX_DIV_STEPS + 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) checkOutput("busy_after_accept", busy, zero_div ? 0 : 1);
            if (done) begin
                seen = 1'b1;
                lat  = c;
                break;
            end
            if (inject && (c % 9 == 4)) begin
                start = 1'b1;
                x_in  = rand163();
                z_in  = (c % 2 == 1) ? '0 : rand163();
            end
        end
        checkOutput("done_seen", seen, 1);
        if (seen) begin
            if (zero_div) checkOutput("zero_latency", lat, 1);
            else checkOutput("latency_bound", (lat <= MAX_DIV_STEPS + 1), 1);
            @(negedge clk);
            checkOutput("done_single_pulse", done, 0);
        end
    endtask

    task automatic applyStimulus(input logic [M-1:0] xv, input logic [M-1:0] zv,
                                 input logic [M-1:0] exp_x, input logic exp_dz, input bit inject);
        start = 1'b1;
        x_in  = xv;
        z_in  = zv;
        sb.push_back('{x: exp_x, dz: exp_dz});
        waitDone(zv == '0, inject);
    endtask

    initial begin
        logic [M-1:0] inv_x, r, xv, zv;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_x_out", x_out, 0);
        checkOutput("rst_div_zero", div_zero, 0);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(163'h5, 163'h1, 163'h5, 1'b0, 1'b0);

        inv_x = '0;
        inv_x[162] = 1'b1;
        inv_x[6]   = 1'b1;
        inv_x[5]   = 1'b1;
        inv_x[2]   = 1'b1;
        applyStimulus(163'h1, 163'h2, inv_x, 1'b0, 1'b0);

        applyStimulus(163'h4, 163'h0, 163'h0, 1'b1, 1'b0);

        for (int i = 0; i < 100; i++) begin
            r = rand163();
            applyStimulus(r, r, 163'h1, 1'b0, (i % 4 == 0));
        end

        zv = rand163();
        zv[M-1] = 1'b1;
        start = 1'b1;
        x_in  = rand163();
        z_in  = zv;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput("busy_mid_iter", busy, 1);
        rst = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_x_out", x_out, 0);
        checkOutput("abort_div_zero", div_zero, 0);
        @(negedge clk);
        checkOutput("abort_hold_busy", busy, 0);
        checkOutput("abort_hold_done", done, 0);
        rst = 1'b1;
        applyStimulus(163'h4, 163'h2, 163'h2, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            xv = rand163();
            zv = rand163();
            applyStimulus(xv, zv, gf_mul(xv, gf_inv(zv)), 1'b0, (i % 2 == 1));
        end

        checkOutput("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
